in_port_unit: RTL and testbench
===============================

// Module: in_port_unit
// PURPOSE
//  Input-port peripheral for the CPU datapath: receiver side of the I/O path that is the
//  counterpart of the output port. An external device pushes 32-bit words through a
//  valid/ready handshake into a small FIFO.
//  The datapath's "in" instruction asserts InPortOut for one or more cycles. The block then
//  presents the head word on its bus-mux input and holds it stable for the whole assertion.
//  The word is popped exactly once per assertion.
// PARAMETERS
//  DATA_W  32  width of port word and bus-mux input
//  DEPTH   4   FIFO entries (power of two, >= 2)
//  ADDR_W  2   log2(DEPTH)
// PORTS
//  clock        in   1       system clock, rising-edge active
//  clear        in   1       asynchronous, active-low reset
//  dev_data     in   DATA_W  word from external device
//  dev_valid    in   1       device offers dev_data this cycle
//  dev_ready    out  1       block accepts word; equals !full
//  InPortOut    in   1       datapath control: drive input-port word onto bus (level, multi-cycle)
//  BusMuxInPort out  DATA_W  word to datapath bus mux (ungated; mux selects with InPortOut)
//  data_avail   out  1       FIFO non-empty
//  fill_count   out  ADDR_W+1 entries currently stored, 0..DEPTH
//  underflow    out  1       sticky: InPortOut accepted while FIFO empty
// BEHAVIOUR
//  Reset (clear=0, async):
//   - FIFO empty: rd_ptr=wr_ptr=0, fill_count=0.
//   - state=IDLE, held=0, underflow=0.
//   - Outputs: dev_ready=1, data_avail=0, BusMuxInPort=0.
//   - clear asserted mid-transfer aborts it: no pop, stored words lost.
//  Push: at a rising edge with dev_valid && dev_ready, write mem[wr_ptr]=dev_data.
//   - wr_ptr wraps modulo DEPTH.
//   - Full: dev_ready=0, no write. dev_valid while full is ignored, not an error.
//  Read FSM, two states:
//   - IDLE: BusMuxInPort = data_avail ? mem[rd_ptr] : 0 (combinational from the registered
//     array, zero latency).
//     Rising edge with InPortOut=1:
//       - non-empty: held<=mem[rd_ptr], rd_ptr++ (wraps), go HOLD.
//       - empty: held<=0, underflow<=1, no pop, go HOLD.
//   - HOLD: BusMuxInPort=held. Stay while InPortOut=1; rising edge with InPortOut=0 -> IDLE.
//     No pops occur in HOLD.
//   - Net effect: the bus value is valid in the same cycle InPortOut rises. The datapath
//     register captures it at the next edge. One pop per InPortOut pulse regardless of
//     pulse length.
//  Simultaneous events:
//   - Push+pop on the same edge: both happen, fill_count unchanged.
//   - Full: no push (dev_ready=0 before the edge), pop proceeds. dev_ready rises the
//     following cycle.
//   - Empty + push + InPortOut on the same edge: underflow set, held=0, pushed word stored
//     (fill_count=1). That word is returned by the next InPortOut pulse.
//  fill_count arithmetic: +1 on push only, -1 on pop only, never outside 0..DEPTH.
//  underflow clears only on reset.
// STRUCTURE
//  - Package in_port_pkg holds DATA_W, DEPTH, ADDR_W and the state enum {IDLE, HOLD}.
//  - One sub-module, in_port_fifo: sync FIFO with push/pop, head, full/empty, count.
//    It is reused later by the output-port buffer.
//  - Top: read FSM, held register, underflow flag, output mux.
// TESTING
//  1 Reset:
//    - Stimulus: clear=0 mid-stream, then release.
//    - Required: dev_ready=1, data_avail=0, fill_count=0, BusMuxInPort=0, underflow=0.
//  2 Basic read:
//    - Stimulus: push 32'h0000_00A5; then InPortOut=1 for 2 cycles.
//    - Required: BusMuxInPort=32'hA5 through the whole pulse; fill_count 1->0 after the
//      first edge.
//  3 Fill and wrap:
//    - Stimulus: push 1,2,3,4; push 5 with dev_valid; then 6 reads.
//    - Required: dev_ready=0 at count=4 and 5 is dropped.
//    - Reads return 1,2,3,4; ptr wrap verified by pushing 7,8 and reading 7,8.
//  4 Long pulse:
//    - Stimulus: push 10,11; InPortOut high 4 cycles.
//    - Required: bus=10 for all 4 cycles, exactly one pop (fill_count=1).
//    - Next pulse returns 11.
//  5 Simultaneous:
//    - Stimulus: full FIFO with dev_valid=1 and InPortOut pulse.
//    - Required: pop only, count 4->3, then push accepted next edge.
//    - Stimulus: empty FIFO with push(32'hDEAD)+InPortOut on the same edge.
//    - Required: underflow=1, bus=0 in HOLD; the next pulse returns 32'hDEAD.
//  6 Reset mid-HOLD:
//    - Stimulus: assert clear asynchronously between edges during HOLD.
//    - Required: immediate IDLE, BusMuxInPort=0, FIFO empty.

Source files
------------

// File: rtl/in_port_unit_pkg.sv
// Shared parameters and types for the CPU input-port unit.
package in_port_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned ADDR_W = 2;
  localparam int unsigned CNT_W  = ADDR_W + 1;

  typedef logic [DATA_W-1:0] word_t;

  // Read-side FSM: IDLE presents the FIFO head, HOLD presents the latched word
  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } rd_state_e;

endpackage

// File: rtl/in_port_unit_if.sv
// Device handshake plus datapath control and status for the input-port unit.
interface in_port_unit_if;
  import in_port_pkg::*;

  logic [DATA_W-1:0] dev_data;
  logic              dev_valid;
  logic              dev_ready;
  logic              InPortOut;
  logic [DATA_W-1:0] BusMuxInPort;
  logic              data_avail;
  logic [CNT_W-1:0]  fill_count;
  logic              underflow;

  // Environment side: device and datapath control
  modport master (
    output dev_data, dev_valid, InPortOut,
    input  dev_ready, BusMuxInPort, data_avail, fill_count, underflow
  );

  // Port unit side
  modport slave (
    input  dev_data, dev_valid, InPortOut,
    output dev_ready, BusMuxInPort, data_avail, fill_count, underflow
  );

endinterface

// File: rtl/in_port_unit_fifo.sv
// Synchronous FIFO with head peek, full/empty flags and an occupancy count.
// Push while full and pop while empty are ignored. DEPTH must be a power of two.
module in_port_fifo
  import in_port_pkg::*;
#(
  parameter int unsigned W  = DATA_W,
  parameter int unsigned D  = DEPTH,
  parameter int unsigned AW = ADDR_W
) (
  input  logic          clock,
  input  logic          clear,
  input  logic          i_push,
  input  logic [W-1:0]  i_wdata,
  input  logic          i_pop,
  output logic [W-1:0]  o_head,
  output logic          o_full,
  output logic          o_empty,
  output logic [AW:0]   o_count
);

  localparam int unsigned CW = AW + 1;

  logic [W-1:0]  r_mem [D];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_full    = (r_count == CW'(D));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_head    = r_mem[r_rd_ptr];
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  // Storage array; cleared on reset so the head never shows stale data
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      for (int i = 0; i < int'(D); i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  // Pointers wrap naturally at the power-of-two depth
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
    end
  end

  // Occupancy: simultaneous push and pop leave it unchanged
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      r_count <= '0;
    end else begin
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/in_port_unit.sv
// CPU input-port unit: buffers device words and hands one word to the datapath
// bus mux per InPortOut assertion, holding it stable for the whole assertion.
module in_port_unit
  import in_port_pkg::*;
(
  input  logic          clock,
  input  logic          clear,
  in_port_unit_if.slave bus
);

  rd_state_e          r_state;
  rd_state_e          w_state_nxt;
  logic [DATA_W-1:0]  r_held;
  logic [DATA_W-1:0]  w_held_nxt;
  logic               r_underflow;
  logic               w_underflow_nxt;
  logic               w_pop;
  logic [DATA_W-1:0]  w_head;
  logic               w_full;
  logic               w_empty;
  logic [CNT_W-1:0]   w_count;

  in_port_fifo #(
    .W  (DATA_W),
    .D  (DEPTH),
    .AW (ADDR_W)
  ) u_fifo (
    .clock   (clock),
    .clear   (clear),
    .i_push  (bus.dev_valid),
    .i_wdata (bus.dev_data),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign bus.dev_ready  = !w_full;
  assign bus.data_avail = !w_empty;
  assign bus.fill_count = w_count;
  assign bus.underflow  = r_underflow;

  // Read FSM, held word and underflow flag registers
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      r_state     <= IDLE;
      r_held      <= '0;
      r_underflow <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_held      <= w_held_nxt;
      r_underflow <= w_underflow_nxt;
    end
  end

  // Next state: the rising InPortOut level pops once, HOLD waits for it to drop
  always_comb begin
    w_state_nxt     = r_state;
    w_held_nxt      = r_held;
    w_underflow_nxt = r_underflow;
    w_pop           = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.InPortOut) begin
          w_state_nxt = HOLD;
          if (!w_empty) begin
            w_pop      = 1'b1;
            w_held_nxt = w_head;
          end else begin
            w_held_nxt      = '0;
            w_underflow_nxt = 1'b1;
          end
        end
      end
      HOLD: begin
        if (!bus.InPortOut) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Bus-mux word: live head in IDLE (zero-latency), latched word in HOLD
  always_comb begin
    bus.BusMuxInPort = '0;
    if (r_state == HOLD) begin
      bus.BusMuxInPort = r_held;
    end else if (!w_empty) begin
      bus.BusMuxInPort = w_head;
    end
  end

endmodule

// File: tb/tb_in_port_unit.sv
// Testbench for in_port_unit: directed vector table, hand-written corner
// sequences and random traffic against a queue-based reference model.
module tb_in_port_unit;
  import in_port_pkg::*;

  logic clock = 1'b0;
  logic clear;

  always #5 clock = ~clock;

  in_port_unit_if u_if ();

  in_port_unit dut (
    .clock (clock),
    .clear (clear),
    .bus   (u_if)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: FIFO contents as a queue, plus the read-side view
  logic [31:0] m_q [$];
  bit          m_hold;
  logic [31:0] m_held;
  bit          m_uf;

  typedef struct {
    logic        v;
    logic [31:0] d;
    logic        ip;
    logic [31:0] bus;
    int          cnt;
    logic        rdy;
    logic        uf;
  } vec_t;

  vec_t tbl [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_hold = 1'b0;
    m_held = '0;
    m_uf   = 1'b0;
  endtask

  // One clock edge of the specified behaviour, using pre-edge occupancy
  task automatic model_edge(input logic v, input logic [31:0] d, input logic ip);
    int pre;
    pre = m_q.size();
    if (!m_hold) begin
      if (ip) begin
        if (pre > 0) begin
          m_held = m_q.pop_front();
        end else begin
          m_held = '0;
          m_uf   = 1'b1;
        end
        m_hold = 1'b1;
      end
    end else if (!ip) begin
      m_hold = 1'b0;
    end
    if (v && pre < int'(DEPTH)) m_q.push_back(d);
  endtask

  task automatic check_model(input string tag);
    logic [31:0] exp_bus;
    exp_bus = m_hold ? m_held : ((m_q.size() > 0) ? m_q[0] : 32'h0);
    chk({tag, ".bus"},   u_if.BusMuxInPort, exp_bus);
    chk({tag, ".count"}, 32'(u_if.fill_count), 32'(m_q.size()));
    chk({tag, ".avail"}, 32'(u_if.data_avail), 32'(m_q.size() > 0));
    chk({tag, ".ready"}, 32'(u_if.dev_ready), 32'(m_q.size() < int'(DEPTH)));
    chk({tag, ".uf"},    32'(u_if.underflow), 32'(m_uf));
  endtask

  task automatic drive(input logic v, input logic [31:0] d, input logic ip);
    @(negedge clock);
    u_if.dev_valid = v;
    u_if.dev_data  = d;
    u_if.InPortOut = ip;
  endtask

  // Drive one cycle, check against the model mid-low-phase, then advance it
  task automatic cycle(input string tag, input logic v, input logic [31:0] d, input logic ip);
    drive(v, d, ip);
    #1;
    check_model(tag);
    @(posedge clock);
    model_edge(v, d, ip);
  endtask

  // Assert clear between edges, check reset outputs at once, then release
  task automatic do_reset(input string tag);
    @(negedge clock);
    #2;
    clear = 1'b0;
    #1;
    model_reset();
    chk({tag, ".rst_ready"}, 32'(u_if.dev_ready), 32'd1);
    chk({tag, ".rst_avail"}, 32'(u_if.data_avail), 32'd0);
    chk({tag, ".rst_count"}, 32'(u_if.fill_count), 32'd0);
    chk({tag, ".rst_bus"},   u_if.BusMuxInPort, 32'd0);
    chk({tag, ".rst_uf"},    32'(u_if.underflow), 32'd0);
    u_if.dev_valid = 1'b0;
    u_if.dev_data  = '0;
    u_if.InPortOut = 1'b0;
    @(negedge clock);
    clear = 1'b1;
  endtask

  task automatic addv(input logic v, input logic [31:0] d, input logic ip,
                      input logic [31:0] b, input int c, input logic r, input logic u);
    vec_t e;
    e.v = v; e.d = d; e.ip = ip; e.bus = b; e.cnt = c; e.rdy = r; e.uf = u;
    tbl.push_back(e);
  endtask

  initial begin
    clear          = 1'b0;
    u_if.dev_valid = 1'b0;
    u_if.dev_data  = '0;
    u_if.InPortOut = 1'b0;
    model_reset();
    repeat (2) @(negedge clock);
    clear = 1'b1;

    // Reset mid-stream with words stored and a read in progress
    cycle("pre", 1'b1, 32'h111, 1'b0);
    cycle("pre", 1'b1, 32'h222, 1'b1);
    do_reset("reset1");

    // Directed table: basic read, fill/drop/wrap, underflow reads, long pulse
    addv(1, 32'hA5, 0, 32'h00, 0, 1, 0);
    addv(0, 0,      1, 32'hA5, 1, 1, 0);
    addv(0, 0,      1, 32'hA5, 0, 1, 0);
    addv(0, 0,      0, 32'hA5, 0, 1, 0);
    addv(1, 1,      0, 32'h00, 0, 1, 0);
    addv(1, 2,      0, 32'h01, 1, 1, 0);
    addv(1, 3,      0, 32'h01, 2, 1, 0);
    addv(1, 4,      0, 32'h01, 3, 1, 0);
    addv(1, 5,      0, 32'h01, 4, 0, 0);
    addv(0, 0,      1, 32'h01, 4, 0, 0);
    addv(0, 0,      0, 32'h01, 3, 1, 0);
    addv(0, 0,      1, 32'h02, 3, 1, 0);
    addv(0, 0,      0, 32'h02, 2, 1, 0);
    addv(0, 0,      1, 32'h03, 2, 1, 0);
    addv(0, 0,      0, 32'h03, 1, 1, 0);
    addv(0, 0,      1, 32'h04, 1, 1, 0);
    addv(0, 0,      0, 32'h04, 0, 1, 0);
    addv(0, 0,      1, 32'h00, 0, 1, 0);
    addv(0, 0,      0, 32'h00, 0, 1, 1);
    addv(0, 0,      1, 32'h00, 0, 1, 1);
    addv(0, 0,      0, 32'h00, 0, 1, 1);
    addv(1, 7,      0, 32'h00, 0, 1, 1);
    addv(1, 8,      0, 32'h07, 1, 1, 1);
    addv(0, 0,      1, 32'h07, 2, 1, 1);
    addv(0, 0,      0, 32'h07, 1, 1, 1);
    addv(0, 0,      1, 32'h08, 1, 1, 1);
    addv(0, 0,      0, 32'h08, 0, 1, 1);
    addv(1, 10,     0, 32'h00, 0, 1, 1);
    addv(1, 11,     0, 32'h0A, 1, 1, 1);
    addv(0, 0,      1, 32'h0A, 2, 1, 1);
    addv(0, 0,      1, 32'h0A, 1, 1, 1);
    addv(0, 0,      1, 32'h0A, 1, 1, 1);
    addv(0, 0,      1, 32'h0A, 1, 1, 1);
    addv(0, 0,      0, 32'h0A, 1, 1, 1);
    addv(0, 0,      1, 32'h0B, 1, 1, 1);
    addv(0, 0,      0, 32'h0B, 0, 1, 1);
    addv(0, 0,      0, 32'h00, 0, 1, 1);

    foreach (tbl[i]) begin
      drive(tbl[i].v, tbl[i].d, tbl[i].ip);
      #1;
      chk($sformatf("vec%0d.bus", i),   u_if.BusMuxInPort, tbl[i].bus);
      chk($sformatf("vec%0d.count", i), 32'(u_if.fill_count), 32'(tbl[i].cnt));
      chk($sformatf("vec%0d.avail", i), 32'(u_if.data_avail), 32'(tbl[i].cnt != 0));
      chk($sformatf("vec%0d.ready", i), 32'(u_if.dev_ready), 32'(tbl[i].rdy));
      chk($sformatf("vec%0d.uf", i),    32'(u_if.underflow), 32'(tbl[i].uf));
      @(posedge clock);
      model_edge(tbl[i].v, tbl[i].d, tbl[i].ip);
    end

    // Full FIFO with push offered and a read on the same edge: pop only
    do_reset("reset2");
    for (int k = 0; k < 4; k++) cycle("fill", 1'b1, 32'(100 + k), 1'b0);
    cycle("fullpop", 1'b1, 32'd99, 1'b1);
    drive(1'b1, 32'd99, 1'b0);
    #1;
    chk("fullpop.count3", 32'(u_if.fill_count), 32'd3);
    chk("fullpop.ready",  32'(u_if.dev_ready), 32'd1);
    chk("fullpop.held",   u_if.BusMuxInPort, 32'd100);
    @(posedge clock);
    model_edge(1'b1, 32'd99, 1'b0);
    drive(1'b0, 32'd0, 1'b0);
    #1;
    chk("fullpop.count4", 32'(u_if.fill_count), 32'd4);
    @(posedge clock);
    model_edge(1'b0, 32'd0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      cycle("drain", 1'b0, 32'd0, 1'b1);
      cycle("drain", 1'b0, 32'd0, 1'b0);
    end

    // Empty FIFO: push and read on the same edge underflow, word kept
    cycle("emptypush", 1'b1, 32'hDEAD, 1'b1);
    drive(1'b0, 32'd0, 1'b1);
    #1;
    chk("emptypush.uf",    32'(u_if.underflow), 32'd1);
    chk("emptypush.bus",   u_if.BusMuxInPort, 32'd0);
    chk("emptypush.count", 32'(u_if.fill_count), 32'd1);
    @(posedge clock);
    model_edge(1'b0, 32'd0, 1'b1);
    cycle("emptypush", 1'b0, 32'd0, 1'b0);
    drive(1'b0, 32'd0, 1'b1);
    #1;
    chk("emptypush.next", u_if.BusMuxInPort, 32'hDEAD);
    @(posedge clock);
    model_edge(1'b0, 32'd0, 1'b1);
    cycle("emptypush", 1'b0, 32'd0, 1'b0);

    // Reset asserted between edges while in HOLD with words stored
    do_reset("reset3");
    cycle("hold", 1'b1, 32'h55, 1'b0);
    cycle("hold", 1'b1, 32'h66, 1'b0);
    cycle("hold", 1'b0, 32'h0, 1'b1);
    cycle("hold", 1'b0, 32'h0, 1'b1);
    do_reset("reset4");

    // Random traffic against the model
    for (int n = 0; n < 1500; n++) begin
      cycle("rand", 1'($urandom_range(0, 2) != 0), $urandom, 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
